uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- Host-side initiator for the UART-to-bus binary command protocol.
- Converts a local bus-access request into a binary command byte stream on a uart_top byte interface (tx_data/new_tx_data/tx_busy), then parses the remote bridge's reply bytes (rx_data/new_rx_data).
- Lets one FPGA drive the register file of another board's UART bridge, and serves as the self-test driver for the bridge.

Parameters:
- TIMEOUT_CYCLES, 24'd5000000, idle clocks allowed between reply bytes before the transfer aborts.
- ACK_BYTE, 8'h5A, byte the remote returns on completion when an ack is requested.

Ports:
- clock  in  1  global clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  request strobe; held until accepted
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  16  start address
- cmd_len  in  8  byte count; 0 means 256
- cmd_noinc  in  1  1 = remote keeps address fixed
- cmd_ack  in  1  1 = request and wait for ACK_BYTE
- wr_data  in  8  write payload byte
- wr_valid  in  1  payload byte available
- wr_ready  out  1  payload byte consumed this cycle
- rd_data  out  8  read payload byte
- rd_valid  out  1  one-cycle strobe per read byte
- done  out  1  one-cycle pulse at transfer end
- error  out  1  valid with done: timeout or wrong ack byte
- tx_data  out  8  byte to uart transmitter
- new_tx_data  out  1  one-cycle transmit strobe
- tx_busy  in  1  transmitter busy
- rx_data  in  8  received byte
- new_rx_data  in  1  received-byte strobe

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, all strobes 0, tx_data/rd_data 8'h00, counters 0, cmd_ready 1.
- Accept: cmd_valid && cmd_ready latches all cmd_* fields. cmd_ready drops the next cycle.
- Header bytes, in order:
  - 8'h00
  - command byte {2'b00, type[1:0], 2'b00, noinc, ack}, where type = 2'b10 write, 2'b01 read
  - addr[15:8]
  - addr[7:0]
  - len[7:0]
- Byte transmit rule: new_tx_data pulses for exactly 1 cycle, with tx_data valid in that same cycle. It pulses only when tx_busy==0 and new_tx_data was 0 in the previous cycle, so the transmitter has one cycle to raise busy.
- States:
  - IDLE -> HDR on accept.
  - HDR sends the 5 header bytes (index counter 0..4), then goes to WDATA for a write or RDATA for a read.
  - WDATA: when wr_valid && transmit allowed, assert wr_ready and new_tx_data in the same cycle with tx_data=wr_data. After the final byte go to ACK if ack, else DONE.
  - RDATA: each new_rx_data gives rd_data=rx_data and rd_valid=1 on the next cycle. After len bytes go to ACK if ack, else DONE.
  - ACK: the first new_rx_data is compared with ACK_BYTE; a mismatch sets error. Then go to DONE.
  - DONE: done=1 for 1 cycle, error qualified, then IDLE (cmd_ready=1 the following cycle).
- Byte count: 9-bit down counter loaded with (len==0 ? 256 : len). The transition fires when the counter reaches 0.
- Timeout: in RDATA/ACK, a counter resets on every new_rx_data. Reaching TIMEOUT_CYCLES forces DONE with error=1; remaining read bytes are dropped.
- In WDATA there is no timeout; wr_valid low simply stalls.
- new_rx_data outside RDATA/ACK is ignored, with no rd_valid.
- Reset mid-transfer returns to IDLE immediately; a partial command already sent is not completed.
- cmd_* changes after accept have no effect.

Decomposition:
- Shared package uart_bus_pkg:
  - command opcodes (NOP 2'b00, READ 2'b01, WRITE 2'b10)
  - binary prefix 8'h00
  - default ACK_BYTE
  - state encoding
- One natural sub-module, uart_tx_pacer: the tx_busy/new_tx_data one-shot pacing logic, reused for header and payload bytes.

Test Plan:
- Write addr 16'h1234, len 2, data A5,3C, ack=1, remote replies 5A -> tx sequence 00,21,12,34,02,A5,3C; done=1, error=0.
- Read addr 16'h0010, len 3, noinc=1, ack=0, rx bytes 11,22,33 -> tx 00,12,00,10,03; rd_valid three times with 11,22,33; done, error=0.
- Read len 0, ack=0 -> tx length byte 00; exactly 256 rd_valid pulses accepted before done.
- tx_busy held high for 1000 cycles during header -> no new_tx_data pulses while busy; no two consecutive-cycle pulses; byte order intact.
- Read len 4, ack=0, only 2 rx bytes with TIMEOUT_CYCLES=100 -> done with error=1 within 101 cycles of the last byte; later rx ignored.
- reset=0 during WDATA byte 1 -> cmd_ready=1 and all strobes 0 after the edge; the next command starts cleanly with a 00 prefix.

Source files
------------

// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the UART-to-bus binary command master.
// Opcodes, prefix byte, defaults and the master FSM encoding.
package uart_bus_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [7:0]  BIN_PREFIX   = 8'h00;
  localparam logic [7:0]  DEF_ACK_BYTE = 8'h5A;
  localparam logic [23:0] DEF_TIMEOUT  = 24'd5000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_RDATA,
    ST_ACK,
    ST_DONE
  } state_t;

  function automatic logic [7:0] cmd_byte(
    input logic [1:0] op,
    input logic       noinc,
    input logic       ack
  );
    return {2'b00, op, 2'b00, noinc, ack};
  endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// Local request/payload bundle plus uart_top byte stream for the bus master.
// master = the bus master itself, slave = the agent driving it.
interface uart_bus_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_noinc;
  logic        cmd_ack;

  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        done;
  logic        error;

  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        new_rx_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_noinc, cmd_ack, wr_data, wr_valid,
    input  tx_busy, rx_data, new_rx_data,
    output cmd_ready, wr_ready, rd_data, rd_valid,
    output done, error, tx_data, new_tx_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_noinc, cmd_ack, wr_data, wr_valid,
    output tx_busy, rx_data, new_rx_data,
    input  cmd_ready, wr_ready, rd_data, rd_valid,
    input  done, error, tx_data, new_tx_data
  );

endinterface

// File: rtl/uart_tx_pacer.sv
// One-shot transmit pacing: fires at most every other cycle and never
// while the transmitter reports busy.
module uart_tx_pacer (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic tx_busy,
  output logic fire
);

  logic last;

  // the gap cycle gives the transmitter time to raise busy
  assign fire = req && !tx_busy && !last;

  always_ff @(posedge clock) begin
    if (!reset) last <= 1'b0;
    else        last <= fire;
  end

endmodule

// File: rtl/uart_bus_master.sv
// Host-side initiator: turns a bus request into a binary command stream
// and collects the remote bridge's read data / ack reply.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE
) (
  input logic               clock,
  input logic               reset,
  uart_bus_master_if.master bus
);

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  c_op;
  logic        c_noinc;
  logic        c_ack;
  logic [15:0] c_addr;
  logic [7:0]  c_len;

  logic [2:0]  hdr_idx;
  logic [8:0]  cnt;
  logic [23:0] tmo;
  logic        err;
  logic [7:0]  rd_data_q;
  logic        rd_valid_q;

  logic        tx_req;
  logic [7:0]  tx_byte;
  logic        fire;
  logic        wr_take;
  logic        accept;
  logic        rx_phase;
  logic        tmo_hit;

  assign accept   = bus.cmd_valid && (state == ST_IDLE);
  assign rx_phase = (state == ST_RDATA) || (state == ST_ACK);
  assign tmo_hit  = rx_phase && !bus.new_rx_data &&
                    (tmo >= TIMEOUT_CYCLES - 24'd1);

  uart_tx_pacer u_pacer (
    .clock   (clock),
    .reset   (reset),
    .req     (tx_req),
    .tx_busy (bus.tx_busy),
    .fire    (fire)
  );

  always_comb begin
    tx_req  = 1'b0;
    tx_byte = 8'h00;
    unique case (state)
      ST_HDR: begin
        tx_req = 1'b1;
        case (hdr_idx)
          3'd0:    tx_byte = BIN_PREFIX;
          3'd1:    tx_byte = cmd_byte(c_op, c_noinc, c_ack);
          3'd2:    tx_byte = c_addr[15:8];
          3'd3:    tx_byte = c_addr[7:0];
          default: tx_byte = c_len;
        endcase
      end
      ST_WDATA: begin
        tx_req  = bus.wr_valid;
        tx_byte = bus.wr_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wr_take   = 1'b0;
    unique case (state)
      ST_IDLE:
        if (bus.cmd_valid) state_nxt = ST_HDR;
      ST_HDR:
        if (fire && hdr_idx == 3'd4)
          state_nxt = (c_op == OP_WRITE) ? ST_WDATA : ST_RDATA;
      ST_WDATA:
        if (fire) begin
          wr_take = 1'b1;
          if (cnt == 9'd1)
            state_nxt = c_ack ? ST_ACK : ST_DONE;
        end
      ST_RDATA:
        if (tmo_hit)
          state_nxt = ST_DONE;
        else if (bus.new_rx_data && cnt == 9'd1)
          state_nxt = c_ack ? ST_ACK : ST_DONE;
      ST_ACK:
        if (bus.new_rx_data || tmo_hit) state_nxt = ST_DONE;
      ST_DONE:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      c_op       <= OP_NOP;
      c_noinc    <= 1'b0;
      c_ack      <= 1'b0;
      c_addr     <= '0;
      c_len      <= '0;
      hdr_idx    <= '0;
      cnt        <= '0;
      tmo        <= '0;
      err        <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (accept) begin
        c_op    <= bus.cmd_write ? OP_WRITE : OP_READ;
        c_noinc <= bus.cmd_noinc;
        c_ack   <= bus.cmd_ack;
        c_addr  <= bus.cmd_addr;
        c_len   <= bus.cmd_len;
        hdr_idx <= '0;
        err     <= 1'b0;
        // a zero length field encodes a full 256-byte burst
        cnt     <= (bus.cmd_len == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len};
      end
      if (state == ST_HDR && fire) hdr_idx <= hdr_idx + 3'd1;
      if (wr_take) cnt <= cnt - 9'd1;
      if (state == ST_RDATA && bus.new_rx_data) begin
        rd_data_q  <= bus.rx_data;
        rd_valid_q <= 1'b1;
        cnt        <= cnt - 9'd1;
      end
      if (state == ST_ACK && bus.new_rx_data)
        err <= (bus.rx_data != ACK_BYTE);
      if (tmo_hit) err <= 1'b1;
      tmo <= (rx_phase && !bus.new_rx_data) ? tmo + 24'd1 : '0;
    end
  end

  assign bus.cmd_ready   = (state == ST_IDLE);
  assign bus.wr_ready    = wr_take;
  assign bus.new_tx_data = fire;
  assign bus.tx_data     = fire ? tx_byte : 8'h00;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.done        = (state == ST_DONE);
  assign bus.error       = (state == ST_DONE) && err;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: models a paced uart_top transmitter,
// feeds write payload and plays back remote reply bytes.
`timescale 1ns/1ps
module tb_uart_bus_master;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] tx_log[$];
  logic [7:0] rd_log[$];
  logic [7:0] wr_q[$];

  int   done_cnt = 0;
  logic last_err = 1'b0;
  int   done_cyc = 0;
  int   rx_cyc = 0;
  int   b2b = 0;
  int   busy_viol = 0;
  logic last_pulse = 1'b0;
  logic pulse_seen = 1'b0;
  logic wr_pop = 1'b0;
  logic force_busy = 1'b0;
  int   busy_cnt = 0;
  int   busy_len = 3;

  uart_bus_master_if bus();

  uart_bus_master #(
    .TIMEOUT_CYCLES (24'd100),
    .ACK_BYTE       (8'h5A)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (bus.new_tx_data === 1'b1) begin
      tx_log.push_back(bus.tx_data);
      if (last_pulse) b2b++;
      if (bus.tx_busy) busy_viol++;
      pulse_seen = 1'b1;
    end
    last_pulse = (bus.new_tx_data === 1'b1);
    if (bus.rd_valid === 1'b1) rd_log.push_back(bus.rd_data);
    if (bus.wr_ready === 1'b1) wr_pop = 1'b1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      last_err = bus.error;
      done_cyc = cyc;
    end
  end

  always @(posedge clock) begin
    #1;
    if (pulse_seen) begin
      busy_cnt = busy_len;
      pulse_seen = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.tx_busy = force_busy || (busy_cnt > 0);
    if (wr_pop) begin
      if (wr_q.size() > 0) void'(wr_q.pop_front());
      wr_pop = 1'b0;
    end
    bus.wr_valid = (wr_q.size() > 0);
    bus.wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
  end

  task automatic nclk();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr,
                       input logic [7:0] len, input logic noinc,
                       input logic ack);
    @(posedge clock); #1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_noinc = noinc;
    bus.cmd_ack   = ack;
    bus.cmd_valid = 1'b1;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~wr;
    bus.cmd_addr  = 16'hFFFF;
    bus.cmd_len   = 8'hFF;
    bus.cmd_noinc = ~noinc;
    bus.cmd_ack   = ~ack;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clock); #1;
    bus.rx_data = b;
    bus.new_rx_data = 1'b1;
    rx_cyc = cyc;
    @(posedge clock); #1;
    bus.new_rx_data = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
      nclk();
    end
  endtask

  task automatic wait_done(input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      nclk();
      if (done_cnt > prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    nclk();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++;
      $display("FAIL rst_cmd_ready got=%b want=1", bus.cmd_ready); end
    checks++; if (bus.new_tx_data !== 1'b0) begin errors++;
      $display("FAIL rst_new_tx got=%b want=0", bus.new_tx_data); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++;
      $display("FAIL rst_wr_ready got=%b want=0", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++;
      $display("FAIL rst_rd_valid got=%b want=0", bus.rd_valid); end
    checks++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin errors++;
      $display("FAIL rst_done got=%b%b want=00", bus.done, bus.error); end
    checks++; if (bus.tx_data !== 8'h00 || bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got=%h/%h want=00/00", bus.tx_data, bus.rd_data); end
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_write();
    logic [7:0] expv[7];
    logic [7:0] got;
    bit ok;
    int d0;
    expv = '{8'h00, 8'h21, 8'h12, 8'h34, 8'h02, 8'hA5, 8'h3C};
    tx_log.delete(); rd_log.delete();
    wr_q.push_back(8'hA5); wr_q.push_back(8'h3C);
    d0 = done_cnt;
    issue(1'b1, 16'h1234, 8'd2, 1'b0, 1'b1);
    nclk();
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++;
      $display("FAIL wr_cmd_ready_drop got=%b want=0", bus.cmd_ready); end
    send_rx(8'hEE);
    wait_tx(7, 500, ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL wr_tx_count got=%0d want=7", tx_log.size()); end
    for (int i = 0; i < 7; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== expv[i]) begin errors++;
        $display("FAIL wr_tx[%0d] got=%h want=%h", i, got, expv[i]); end
    end
    send_rx(8'h5A);
    wait_done(d0, 50, ok);
    checks++; if (!ok || last_err !== 1'b0) begin errors++;
      $display("FAIL wr_done got=%0b err=%b want=1 err=0", ok, last_err); end
    checks++; if (rd_log.size() != 0 || wr_q.size() != 0) begin errors++;
      $display("FAIL wr_queues got rd=%0d wrq=%0d want 0/0",
               rd_log.size(), wr_q.size()); end
    nclk();
    checks++; if (bus.cmd_ready !== 1'b1 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL wr_idle got ready=%b dones=%0d want 1/%0d",
               bus.cmd_ready, done_cnt - d0, 1); end
  endtask

  task automatic test_read_noinc();
    logic [7:0] expv[5];
    logic [7:0] expr[3];
    logic [7:0] got;
    bit ok;
    int d0;
    expv = '{8'h00, 8'h12, 8'h00, 8'h10, 8'h03};
    expr = '{8'h11, 8'h22, 8'h33};
    tx_log.delete(); rd_log.delete();
    busy_len = 0;
    b2b = 0;
    d0 = done_cnt;
    issue(1'b0, 16'h0010, 8'd3, 1'b1, 1'b0);
    wait_tx(5, 200, ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL rd_tx_count got=%0d want=5", tx_log.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== expv[i]) begin errors++;
        $display("FAIL rd_tx[%0d] got=%h want=%h", i, got, expv[i]); end
    end
    checks++; if (b2b != 0) begin errors++;
      $display("FAIL rd_b2b_pulses got=%0d want=0", b2b); end
    busy_len = 3;
    send_rx(8'h11); send_rx(8'h22);
    nclk();
    send_rx(8'h33);
    wait_done(d0, 20, ok);
    checks++; if (!ok || last_err !== 1'b0) begin errors++;
      $display("FAIL rd_done got=%0b err=%b want=1 err=0", ok, last_err); end
    checks++; if (rd_log.size() != 3) begin errors++;
      $display("FAIL rd_count got=%0d want=3", rd_log.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rd_log.size()) ? rd_log[i] : 8'hxx;
      checks++; if (got !== expr[i]) begin errors++;
        $display("FAIL rd_data[%0d] got=%h want=%h", i, got, expr[i]); end
    end
  endtask

  task automatic test_len0();
    logic [7:0] b;
    bit ok;
    int d0;
    int nbad;
    tx_log.delete(); rd_log.delete();
    d0 = done_cnt;
    issue(1'b0, 16'h0200, 8'd0, 1'b0, 1'b0);
    wait_tx(5, 200, ok);
    checks++; if (!ok || tx_log[1] !== 8'h10 || tx_log[2] !== 8'h02 ||
                  tx_log[4] !== 8'h00) begin errors++;
      $display("FAIL l0_hdr got ok=%0b cmd=%h ah=%h len=%h want 10/02/00",
               ok, tx_log[1], tx_log[2], tx_log[4]); end
    for (int i = 0; i < 255; i++) begin
      b = i[7:0];
      send_rx(b);
    end
    nclk();
    checks++; if (done_cnt != d0) begin errors++;
      $display("FAIL l0_early_done got=%0d want=0", done_cnt - d0); end
    send_rx(8'hFF);
    wait_done(d0, 10, ok);
    checks++; if (!ok || last_err !== 1'b0) begin errors++;
      $display("FAIL l0_done got=%0b err=%b want=1 err=0", ok, last_err); end
    nbad = 0;
    for (int i = 0; i < rd_log.size(); i++) begin
      b = i[7:0];
      if (rd_log[i] !== b) nbad++;
    end
    checks++; if (rd_log.size() != 256 || nbad != 0) begin errors++;
      $display("FAIL l0_rd got n=%0d bad=%0d want n=256 bad=0",
               rd_log.size(), nbad); end
    send_rx(8'h77);
    repeat (3) nclk();
    checks++; if (rd_log.size() != 256 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL l0_idle_rx got n=%0d dones=%0d want 256/1",
               rd_log.size(), done_cnt - d0); end
  endtask

  task automatic test_busy_nak();
    logic [7:0] expv[5];
    logic [7:0] got;
    bit ok;
    int d0;
    expv = '{8'h00, 8'h11, 8'hBE, 8'hEF, 8'h01};
    tx_log.delete(); rd_log.delete();
    b2b = 0; busy_viol = 0;
    d0 = done_cnt;
    issue(1'b0, 16'hBEEF, 8'd1, 1'b0, 1'b1);
    wait_tx(1, 100, ok);
    force_busy = 1'b1;
    repeat (1000) nclk();
    checks++; if (!ok || tx_log.size() != 1) begin errors++;
      $display("FAIL busy_hold got=%0d want=1", tx_log.size()); end
    force_busy = 1'b0;
    wait_tx(5, 200, ok);
    for (int i = 0; i < 5; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== expv[i]) begin errors++;
        $display("FAIL busy_tx[%0d] got=%h want=%h", i, got, expv[i]); end
    end
    checks++; if (b2b != 0 || busy_viol != 0) begin errors++;
      $display("FAIL busy_pacing got b2b=%0d viol=%0d want 0/0",
               b2b, busy_viol); end
    send_rx(8'h42);
    send_rx(8'hA5);
    wait_done(d0, 20, ok);
    checks++; if (!ok || last_err !== 1'b1) begin errors++;
      $display("FAIL nak_error got=%0b err=%b want=1 err=1", ok, last_err); end
    checks++; if (rd_log.size() != 1 || rd_log[0] !== 8'h42) begin errors++;
      $display("FAIL nak_rd got n=%0d want n=1 data=42", rd_log.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    int d0;
    int diff;
    tx_log.delete(); rd_log.delete();
    d0 = done_cnt;
    issue(1'b0, 16'h0040, 8'd4, 1'b0, 1'b0);
    wait_tx(5, 200, ok);
    send_rx(8'h11);
    send_rx(8'h22);
    wait_done(d0, 150, ok);
    diff = done_cyc - rx_cyc;
    checks++; if (!ok || last_err !== 1'b1) begin errors++;
      $display("FAIL tmo_done got=%0b err=%b want=1 err=1", ok, last_err); end
    checks++; if (diff < 99 || diff > 101) begin errors++;
      $display("FAIL tmo_latency got=%0d want 99..101", diff); end
    send_rx(8'h33);
    send_rx(8'h44);
    repeat (5) nclk();
    checks++; if (rd_log.size() != 2 || rd_log[0] !== 8'h11 ||
                  rd_log[1] !== 8'h22) begin errors++;
      $display("FAIL tmo_rd got n=%0d want n=2 11,22", rd_log.size()); end
    checks++; if (done_cnt != d0 + 1) begin errors++;
      $display("FAIL tmo_late_rx got dones=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    tx_log.delete(); rd_log.delete();
    wr_q.push_back(8'hC3);
    issue(1'b1, 16'h0300, 8'd3, 1'b0, 1'b0);
    wait_tx(6, 200, ok);
    repeat (4) nclk();
    checks++; if (!ok || tx_log[5] !== 8'hC3) begin errors++;
      $display("FAIL mid_wdata got ok=%0b n=%0d want 6 bytes", ok,
               tx_log.size()); end
    d0 = done_cnt;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock);
    nclk();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.new_tx_data !== 1'b0 ||
                  bus.wr_ready !== 1'b0 || bus.done !== 1'b0 ||
                  bus.rd_valid !== 1'b0) begin errors++;
      $display("FAIL mid_reset got rdy=%b tx=%b wr=%b dn=%b rv=%b want 10000",
               bus.cmd_ready, bus.new_tx_data, bus.wr_ready, bus.done,
               bus.rd_valid); end
    @(posedge clock); #1;
    reset = 1'b1;
    tx_log.delete();
    issue(1'b0, 16'h0301, 8'd1, 1'b0, 1'b0);
    wait_tx(5, 200, ok);
    checks++; if (!ok || tx_log[0] !== 8'h00 || tx_log[1] !== 8'h10 ||
                  tx_log[3] !== 8'h01) begin errors++;
      $display("FAIL mid_restart got %h %h %h want 00 10 01",
               tx_log[0], tx_log[1], tx_log[3]); end
    send_rx(8'h66);
    wait_done(d0, 20, ok);
    checks++; if (!ok || last_err !== 1'b0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL mid_done got=%0b err=%b dones=%0d want 1/0/1",
               ok, last_err, done_cnt - d0); end
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = 16'h0000;
    bus.cmd_len     = 8'h00;
    bus.cmd_noinc   = 1'b0;
    bus.cmd_ack     = 1'b0;
    bus.wr_data     = 8'h00;
    bus.wr_valid    = 1'b0;
    bus.tx_busy     = 1'b0;
    bus.rx_data     = 8'h00;
    bus.new_rx_data = 1'b0;
    test_reset();
    test_write();
    test_read_noinc();
    test_len0();
    test_busy_nak();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
